// File: rtl/pipe_pkg.sv
// Shared constants for the generic pipeline stage register: control bit
// positions, default widths and the occupancy encoding.
package pipe_pkg;

  localparam int unsigned CTRL_MEMTOREG = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 3;

  localparam int unsigned CTRL_W_DEF = 4;
  // alu_result 32 + read_data 32 + rt_data 32 + write_reg 5
  localparam int unsigned DATA_W_DEF = 101;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid + ctrl + data. Ctrl is zeroed whenever the slot
// empties, so an empty slot never carries live control bits.
module pipe_slot #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Flush beats load; data is deliberately kept so the payload stays stable.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = load_ctrl;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, ctrl squash and
// stall counter. Define PIPE_SKID_EN for a registered-ready two-slot skid stage.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept, fire, main_take;
  logic              main_valid, skid_valid;
  logic              main_load, main_clear;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic [DATA_W-1:0] main_src_data;
  occ_e              occ;

  assign accept    = in_valid & in_ready;
  assign fire      = main_valid & out_ready;
  assign main_take = !main_valid | fire;

`ifdef PIPE_SKID_EN
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Ready comes straight from the skid register, breaking the ready chain.
  assign in_ready = !skid_valid;

  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    main_src_ctrl = in_ctrl;
    main_src_data = in_data;
    if (main_take) begin
      if (skid_valid) begin
        main_load     = 1'b1;
        main_src_ctrl = skid_ctrl;
        main_src_data = skid_data;
        skid_load     = accept;
        skid_clear    = !accept;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (skid_load),
    .clear    (skid_clear),
    .load_ctrl(in_ctrl),
    .load_data(in_data),
    .valid    (skid_valid),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );
`else
  assign in_ready   = !main_valid | out_ready;
  assign skid_valid = 1'b0;

  always_comb begin
    main_load     = main_take & accept;
    main_clear    = main_take & !accept;
    main_src_ctrl = in_ctrl;
    main_src_data = in_data;
  end
`endif

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (main_load),
    .clear    (main_clear),
    .load_ctrl(main_src_ctrl),
    .load_data(main_src_data),
    .valid    (main_valid),
    .ctrl     (out_ctrl),
    .data     (out_data)
  );

  assign out_valid = main_valid;

  always_comb begin
    occ = OccEmpty;
    case ({main_valid, skid_valid})
      2'b10, 2'b01: occ = OccOne;
      2'b11:        occ = OccTwo;
      default:      occ = OccEmpty;
    endcase
  end

  assign occupancy = occ;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating: holds at all-ones rather than wrapping; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expectations follow the
// PIPE_SKID_EN setting of the build.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset, flush;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_ctrl, out_ctrl;
  logic [100:0] in_data, out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0]   s_in_ctrl, s_out_ctrl;
  logic [7:0]   s_in_data, s_out_data;
  logic [1:0]   s_occupancy;
  logic [2:0]   s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PIPE_SKID_EN
  localparam logic [1:0] OccBackpressure = 2'd2;
`else
  localparam logic [1:0] OccBackpressure = 2'd1;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W(4),
    .DATA_W(8),
    .CNT_W (3)
  ) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_ctrl  (s_in_ctrl),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_ctrl (s_out_ctrl),
    .out_data (s_out_data),
    .occupancy(s_occupancy),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'hF; in_data = 101'h55; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_ctrl = 4'h0; s_in_data = 8'h00; s_out_ready = 1'b0;

    // Reset held two cycles with live input
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0; in_valid = 1'b0; in_ctrl = 4'h0;

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 101'(i); in_ctrl = 4'h1;
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, i);
      check("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl", out_ctrl, 0);
    check("stream_drain_data", out_data, 4);
    check("stream_stall", stall_cnt, 0);

    // Backpressure: A then B with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 101'h10; in_ctrl = 4'h2;
    tick();
    check("bp_a_data", out_data, 'h10);
    check("bp_a_occ", occupancy, 1);
    check("bp_a_stall", stall_cnt, 0);
    in_data = 101'h20; in_ctrl = 4'h4;
    tick();
    check("bp_b_occ", occupancy, OccBackpressure);
    check("bp_b_in_ready", in_ready, 0);
    check("bp_b_stall", stall_cnt, 1);
    check("bp_b_head", out_data, 'h10);
    tick();
    check("bp_hold_occ", occupancy, OccBackpressure);
    check("bp_hold_stall", stall_cnt, 2);
    check("bp_hold_head", out_data, 'h10);
    out_ready = 1'b1;
    tick();
    check("bp_rel_data", out_data, 'h20);
    check("bp_rel_ctrl", out_ctrl, 4'h4);
    check("bp_rel_occ", occupancy, 1);
    check("bp_rel_stall", stall_cnt, 2);
    in_valid = 1'b0;
    tick();
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_occ", occupancy, 0);

    // Flush while holding A and B, with C offered in the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 101'h10; in_ctrl = 4'hA;
    tick();
    in_data = 101'h20; in_ctrl = 4'hB;
    tick();
    check("fl_pre_occ", occupancy, OccBackpressure);
    flush = 1'b1; in_data = 101'h30; in_ctrl = 4'hC;
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_occ", occupancy, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_data_kept", out_data, 'h10);
    check("fl_stall_kept", stall_cnt, 4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_no_c_valid", out_valid, 0);
    check("fl_no_c_data", out_data, 'h10);

    // Ctrl squash after drain; payload stays
    in_valid = 1'b1; in_ctrl = 4'b1010; in_data = 101'hABC;
    tick();
    check("sq_live_ctrl", out_ctrl, 4'b1010);
    in_valid = 1'b0;
    tick();
    check("sq_valid", out_valid, 0);
    check("sq_ctrl", out_ctrl, 0);
    check("sq_data", out_data, 'hABC);

    // Reset mid-transfer
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'h2; in_data = 101'h77;
    tick();
    check("mr_loaded", out_valid, 1);
    reset = 1'b1;
    tick();
    check("mr_valid", out_valid, 0);
    check("mr_occ", occupancy, 0);
    check("mr_stall", stall_cnt, 0);
    check("mr_data", out_data, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();

    // Saturation on the 3-bit counter instance
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_in_ctrl = 4'h8; s_out_ready = 1'b0;
    tick();
    check("sat_valid", s_out_valid, 1);
    check("sat_data", s_out_data, 8'h5A);
    check("sat_start", s_stall_cnt, 0);
    s_in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_cnt = (k < 7) ? k : 7;
      check("sat_cnt", s_stall_cnt, exp_cnt);
    end
    s_out_ready = 1'b1;
    tick();
    check("sat_hold", s_stall_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
